// File: rtl/rx78_pkg.sv
// rtl/rx78_pkg.sv - shared types and constants for the RX-78 upload path
// Purpose: state encoding and fill byte for the hps_io upload read engine.
// Ports: none (package).

package rx78_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } upload_state_t;

  // Byte returned for out-of-image addresses and abandoned accesses.
  localparam logic [7:0] UPLOAD_FILL = 8'hFF;

endpackage

// File: rtl/rx78_upload_csum.sv
// rtl/rx78_upload_csum.sv - running mod-256 sum of uploaded bytes
// Purpose: accumulates every byte handed to the HPS during an upload session.
// Ports:
//   clk_i    in  1  system clock
//   reset_i  in  1  synchronous active-high reset
//   clear_i  in  1  session restart, zeroes the sum
//   add_i    in  1  add byte_i this cycle
//   byte_i   in  8  byte to accumulate
//   csum_o   out 8  current sum

module rx78_upload_csum (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [7:0] byte_i,
  output logic [7:0] csum_o
);

  logic [7:0] csum_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      csum_q <= 8'h00;
    end else if (add_i) begin
      csum_q <= csum_q + byte_i;
    end
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/rx78_ioctl_upload.sv
// rtl/rx78_ioctl_upload.sv - hps_io upload byte reader over a granted memory port
// Purpose: turns each ioctl_rd strobe into one request on a variable-latency
//   byte memory, stalls the HPS via ioctl_wait until the byte is on ioctl_din.
// Build option: UPLOAD_CSUM_EN adds a running checksum on csum_o (else 8'h00).
// Ports:
//   clk_sys_i       in  1   system clock
//   reset_i         in  1   synchronous active-high reset
//   ioctl_upload_i  in  1   upload session active
//   ioctl_rd_i      in  1   read strobe, address valid same cycle
//   ioctl_addr_i    in  25  byte address
//   ioctl_din_o     out 8   read data to HPS
//   ioctl_wait_o    out 1   HPS stall
//   mem_req_o       out 1   memory request, held until grant
//   mem_addr_o      out AW  request address
//   mem_gnt_i       in  1   request accepted
//   mem_rvalid_i    in  1   read data valid strobe
//   mem_rdata_i     in  8   read data
//   err_o           out 1   sticky timeout flag for this session
//   csum_o          out 8   running byte sum

module rx78_ioctl_upload
  import rx78_pkg::*;
#(
  parameter int AW      = 16,
  parameter int SIZE    = 65536,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_sys_i,
  input  logic          reset_i,
  input  logic          ioctl_upload_i,
  input  logic          ioctl_rd_i,
  input  logic [24:0]   ioctl_addr_i,
  output logic [7:0]    ioctl_din_o,
  output logic          ioctl_wait_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [7:0]    mem_rdata_i,
  output logic          err_o,
  output logic [7:0]    csum_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [31:0]   SizeW     = SIZE;
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  upload_state_t state_q;
  logic [7:0]    ioctl_din_q;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic          err_q;
  logic [TW-1:0] timer_q;
  logic          upload_q;

  logic [31:0] addr_ext;
  logic        upload_rise;
  logic        timer_expired;

  assign addr_ext      = {7'd0, ioctl_addr_i};
  assign upload_rise   = ioctl_upload_i & ~upload_q;
  // >= rather than ==: a grant taken on the last REQ cycle pushes the timer
  // one past TimerLast, and DATA must still see it as expired.
  assign timer_expired = (timer_q >= TimerLast);

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ioctl_din_q <= UPLOAD_FILL;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      err_q       <= 1'b0;
      timer_q     <= '0;
      upload_q    <= 1'b0;
    end else begin
      upload_q <= ioctl_upload_i;
      if (upload_rise) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (ioctl_rd_i && ioctl_upload_i) begin
            // Full 25-bit compare: high address bits never alias into the image.
            if (addr_ext >= SizeW) begin
              ioctl_din_q <= UPLOAD_FILL;
              state_q     <= DONE;
            end else begin
              mem_addr_q <= ioctl_addr_i[AW-1:0];
              mem_req_q  <= 1'b1;
              timer_q    <= '0;
              state_q    <= REQ;
            end
          end
        end
        REQ: begin
          if (!ioctl_upload_i) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            timer_q   <= timer_q + 1'b1;
            if (mem_rvalid_i) begin
              ioctl_din_q <= mem_rdata_i;
              state_q     <= DONE;
            end else begin
              state_q <= DATA;
            end
          end else if (timer_expired) begin
            ioctl_din_q <= UPLOAD_FILL;
            err_q       <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          if (mem_rvalid_i) begin
            // A byte arriving as the session ends is consumed but not returned.
            if (ioctl_upload_i) begin
              ioctl_din_q <= mem_rdata_i;
              state_q     <= DONE;
            end else begin
              state_q <= IDLE;
            end
          end else if (!ioctl_upload_i) begin
            timer_q <= '0;
            state_q <= DRAIN;
          end else if (timer_expired) begin
            // Granted read still outstanding: drain it so it cannot be
            // mistaken for the answer to the next request.
            ioctl_din_q <= UPLOAD_FILL;
            err_q       <= 1'b1;
            timer_q     <= '0;
            state_q     <= DRAIN;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        DRAIN: begin
          if (mem_rvalid_i || timer_expired) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ioctl_wait_o = (ioctl_rd_i & ioctl_upload_i & (state_q == IDLE)) | (state_q != IDLE);
  assign ioctl_din_o  = ioctl_din_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign err_o        = err_q;

`ifdef UPLOAD_CSUM_EN
  // DONE lasts exactly one cycle and is only entered with a real or fill
  // byte already latched, so summing ioctl_din there counts each byte once.
  rx78_upload_csum u_csum (
    .clk_i   (clk_sys_i),
    .reset_i (reset_i),
    .clear_i (upload_rise),
    .add_i   (state_q == DONE),
    .byte_i  (ioctl_din_q),
    .csum_o  (csum_o)
  );
`else
  assign csum_o = 8'h00;
`endif

endmodule

// File: tb/tb_rx78_ioctl_upload.sv
// tb/tb_rx78_ioctl_upload.sv - directed scoreboard bench for rx78_ioctl_upload

module tb_rx78_ioctl_upload;

  localparam int AW      = 16;
  localparam int SIZE    = 65536;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          upload;
  logic          rd;
  logic [24:0]   addr;
  logic [7:0]    din;
  logic          wait_o;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          gnt;
  logic          rvalid;
  logic [7:0]    rdata;
  logic          err;
  logic [7:0]    csum;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  logic [7:0] model_sum;
  logic [7:0] last_din;

  int  req_rises = 0;
  int  gnt_cnt   = 0;
  logic req_prev = 1'b0;

  rx78_ioctl_upload #(.AW(AW), .SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys_i      (clk),
    .reset_i        (reset),
    .ioctl_upload_i (upload),
    .ioctl_rd_i     (rd),
    .ioctl_addr_i   (addr),
    .ioctl_din_o    (din),
    .ioctl_wait_o   (wait_o),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_gnt_i      (gnt),
    .mem_rvalid_i   (rvalid),
    .mem_rdata_i    (rdata),
    .err_o          (err),
    .csum_o         (csum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_prev <= mem_req;
    if (mem_req && !req_prev) req_rises <= req_rises + 1;
    if (mem_req && gnt) gnt_cnt <= gnt_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_csum();
`ifdef UPLOAD_CSUM_EN
    return model_sum;
`else
    return 8'h00;
`endif
  endfunction

  // Drive a one-cycle read strobe; wait must already be high in that cycle.
  task automatic strobe(input string tag, input logic [24:0] a);
    rd   = 1'b1;
    addr = a;
    #1;
    chk({tag, "_strobe_wait"}, wait_o, 1'b1);
    tick();
    rd = 1'b0;
  endtask

  // Run until the HPS is released, then retire the oldest expected byte.
  task automatic complete(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (wait_o === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_released"}, wait_o, 1'b0);
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      model_sum = model_sum + e;
      last_din  = e;
      chk({tag, "_din"}, din, e);
    end
  endtask

  task automatic session_restart();
    upload = 1'b0;
    tick();
    upload = 1'b1;
    tick();
    model_sum = 8'h00;
  endtask

  initial begin
    int cnt;
    int rises0;
    int gnts0;
    reset = 1'b1; upload = 1'b0; rd = 1'b0; addr = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 8'h00;
    model_sum = 8'h00; last_din = 8'hFF;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_din", din, 8'hFF);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_err", err, 1'b0);
    chk("rst_csum", csum, 8'h00);
    chk("rst_wait", wait_o, 1'b0);

    upload = 1'b1;
    tick();

    // Normal read: grant after 2 cycles, data 3 cycles later.
    sb.push_back(8'h5A);
    strobe("rd10", 25'h0010);
    chk("rd10_req", mem_req, 1'b1);
    chk("rd10_addr", mem_addr, 16'h0010);
    tick();
    gnt = 1'b1; tick(); gnt = 1'b0;
    chk("rd10_req_drop", mem_req, 1'b0);
    tick(); tick();
    rvalid = 1'b1; rdata = 8'h5A; tick(); rvalid = 1'b0;
    chk("rd10_done_wait", wait_o, 1'b1);
    tick();
    chk("rd10_wait_low", wait_o, 1'b0);
    complete("rd10");

    // Never granted: request abandoned after TIMEOUT cycles.
    sb.push_back(8'hFF);
    strobe("tmo", 25'h0020);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("tmo_req_cycles", cnt, TIMEOUT);
    chk("tmo_err", err, 1'b1);
    chk("tmo_done_wait", wait_o, 1'b1);
    complete("tmo");

    // Out-of-image address: no memory access, wait high exactly 2 cycles.
    sb.push_back(8'hFF);
    rises0 = req_rises;
    rd = 1'b1; addr = 25'h10000; #1;
    cnt = 0;
    while (wait_o === 1'b1 && cnt < 10) begin
      cnt++;
      tick();
      rd = 1'b0;
    end
    chk("fill_wait_cycles", cnt, 2);
    chk("fill_no_req", req_rises - rises0, 0);
    complete("fill");
    chk("fill_err_sticky", err, 1'b1);
    chk("sessA_csum", csum, exp_csum());

    // Upload dropped after grant: the late byte is drained, not returned.
    strobe("drn", 25'h0030);
    gnt = 1'b1; tick(); gnt = 1'b0;
    upload = 1'b0;
    tick();
    chk("drn_wait", wait_o, 1'b1);
    tick();
    rvalid = 1'b1; rdata = 8'h33; tick(); rvalid = 1'b0;
    chk("drn_idle", wait_o, 1'b0);
    chk("drn_din", din, last_din);
    chk("drn_req", mem_req, 1'b0);

    upload = 1'b1;
    tick();
    model_sum = 8'h00;
    chk("rise_err_clr", err, 1'b0);
    chk("rise_csum_clr", csum, 8'h00);

    // Minimum latency: grant and data in the same cycle.
    sb.push_back(8'h80);
    strobe("fast", 25'h0100);
    gnt = 1'b1; rvalid = 1'b1; rdata = 8'h80; tick();
    gnt = 1'b0; rvalid = 1'b0;
    chk("fast_done_wait", wait_o, 1'b1);
    tick();
    chk("fast_wait_low", wait_o, 1'b0);
    complete("fast");

    sb.push_back(8'h90);
    strobe("rd90", 25'h0101);
    gnt = 1'b1; tick(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 8'h90; tick(); rvalid = 1'b0;
    complete("rd90");

    // Extra strobe while a request is pending must not issue a second one.
    sb.push_back(8'h10);
    rises0 = req_rises;
    gnts0  = gnt_cnt;
    strobe("dbl", 25'h0040);
    rd = 1'b1; addr = 25'h0041; tick(); rd = 1'b0;
    chk("dbl_addr", mem_addr, 16'h0040);
    gnt = 1'b1; tick(); gnt = 1'b0;
    tick(); tick();
    rvalid = 1'b1; rdata = 8'h10; tick(); rvalid = 1'b0;
    complete("dbl");
    tick(); tick();
    chk("dbl_one_req", req_rises - rises0, 1);
    chk("dbl_one_gnt", gnt_cnt - gnts0, 1);
    chk("sessB_csum", csum, exp_csum());

    session_restart();
    chk("restart_csum", csum, 8'h00);

    // Reset mid-request; a stale data strobe afterwards is ignored.
    strobe("rstm", 25'h0050);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstm_req", mem_req, 1'b0);
    chk("rstm_wait", wait_o, 1'b0);
    rvalid = 1'b1; rdata = 8'hAB; tick(); rvalid = 1'b0;
    tick();
    chk("rstm_din", din, 8'hFF);
    chk("rstm_idle", wait_o, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
